master_port: RTL and testbench

- Initiator end of the serial system bus; counterpart of the 2K slave.
- Takes a parallel read or write request from a local client and serializes the frame onto the bus: address, slave acknowledge, data, write acknowledge.
- Returns read data in parallel and reports completion or timeout error.
- Sits between a client (CPU stub or testbench) and the bus address decoder/mux.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/master_port_counter.sv | 22 ++
 rtl/master_port.sv | 227 ++++++++++++++++++++++
 tb/tb_master_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: master FSM states, default widths
// and the read/write encoding carried on B_RW.
package bus_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 8;

  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADDR,
    ACKA,
    WDATA,
    ACKW,
    RDATA,
    DONE
  } mstate_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_port_counter.sv
// Up-counter with synchronous clear (priority) and increment enable.
module master_port_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         rst,
  input  logic         incr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count <= '0;
    end else if (rst) begin
      count <= '0;
    end else if (incr) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/master_port.sv
// Serial bus master: turns a parallel client request into an address/ack/data/ack frame.
// Define MASTER_ARB_EN to add the B_REQ/B_GRANT arbitration handshake.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = 15,
  parameter int RD_LAT      = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              M_START,
  input  logic              M_RW,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_DIN,
  output logic              M_BUSY,
  output logic [DATA_W-1:0] M_DOUT,
  output logic              M_DVALID,
  output logic              M_ERR,
  output logic              B_VALID,
  output logic              B_RW,
  output logic              B_BUS_OUT,
  input  logic              B_BUS_IN,
  input  logic              B_ACK,
  input  logic              B_SBSY,
`ifdef MASTER_ARB_EN
  output logic              B_REQ,
  input  logic              B_GRANT,
`endif
  input  logic              B_READY
);

  localparam int BIT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam int CNT_W = $clog2(max_int(ACK_TIMEOUT, RD_LAT) + 1);

  mstate_t             state;
  logic [ADDR_W-1:0]   addr_sh;
  logic [DATA_W-1:0]   data_sh;
  logic [DATA_W-2:0]   rd_sh;
  logic                rd_active;
  logic                bit_rst, bit_incr, tmo_rst, tmo_incr;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                ack_wait, timed_out, grant_lost, abort, wait_go;
  logic                unused_ready;

  // B_READY is observed by the system but has no influence on the frame
  assign unused_ready = B_READY;

  assign ack_wait  = (state == ACKA) || (state == ACKW) || ((state == RDATA) && !rd_active);
  assign timed_out = ((state == ACKA) || (state == ACKW)) && !B_ACK &&
                     (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

`ifdef MASTER_ARB_EN
  assign grant_lost = !B_GRANT && !(state inside {IDLE, WAIT, DONE});
  assign wait_go    = !B_SBSY && B_GRANT;
`else
  assign grant_lost = 1'b0;
  assign wait_go    = !B_SBSY;
`endif

  assign abort = grant_lost || timed_out;

  // The timeout counter doubles as the read-latency counter: any high B_ACK restarts it,
  // so RD_LAT is measured from the last cycle the slave held ACK.
  always_comb begin
    bit_rst  = 1'b1;
    bit_incr = 1'b0;
    tmo_rst  = 1'b0;
    tmo_incr = 1'b0;
    case (state)
      ADDR, WDATA: begin
        bit_rst  = 1'b0;
        bit_incr = 1'b1;
        tmo_rst  = 1'b1;
      end
      RDATA: begin
        if (rd_active) begin
          bit_rst  = 1'b0;
          bit_incr = 1'b1;
        end
      end
      default: ;
    endcase
    if (ack_wait) begin
      if (B_ACK) tmo_rst  = 1'b1;
      else       tmo_incr = 1'b1;
    end else if (state inside {IDLE, WAIT, DONE}) begin
      tmo_rst = 1'b1;
    end
  end

  master_port_counter #(.W(BIT_W)) u_bit_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .rst   (bit_rst),
    .incr  (bit_incr),
    .count (bit_cnt)
  );

  master_port_counter #(.W(CNT_W)) u_tmo_cnt (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .rst   (tmo_rst),
    .incr  (tmo_incr),
    .count (tmo_cnt)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      M_BUSY    <= 1'b0;
      M_DOUT    <= '0;
      M_DVALID  <= 1'b0;
      M_ERR     <= 1'b0;
      B_VALID   <= 1'b0;
      B_RW      <= 1'b0;
      B_BUS_OUT <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      rd_sh     <= '0;
      rd_active <= 1'b0;
`ifdef MASTER_ARB_EN
      B_REQ     <= 1'b0;
`endif
    end else begin
      M_DVALID <= 1'b0;
      M_ERR    <= 1'b0;
      if (abort) begin
        M_ERR     <= 1'b1;
        B_VALID   <= 1'b0;
        B_BUS_OUT <= 1'b0;
        rd_active <= 1'b0;
`ifdef MASTER_ARB_EN
        B_REQ     <= 1'b0;
`endif
        state     <= IDLE;
      end else begin
        case (state)
          // M_BUSY lingers through the error-pulse cycle, so a start there is still refused
          IDLE: begin
            if (M_START && !M_BUSY) begin
              M_BUSY  <= 1'b1;
              B_RW    <= M_RW;
              addr_sh <= M_ADDR;
              data_sh <= M_DIN;
`ifdef MASTER_ARB_EN
              B_REQ   <= 1'b1;
`endif
              state   <= WAIT;
            end else begin
              M_BUSY <= 1'b0;
            end
          end
          WAIT: begin
            if (wait_go) begin
              B_VALID   <= 1'b1;
              B_BUS_OUT <= addr_sh[0];
              addr_sh   <= addr_sh >> 1;
              state     <= ADDR;
            end
          end
          ADDR: begin
            if (bit_cnt == BIT_W'(ADDR_W - 1)) begin
              B_BUS_OUT <= 1'b0;
              state     <= ACKA;
            end else begin
              B_BUS_OUT <= addr_sh[0];
              addr_sh   <= addr_sh >> 1;
            end
          end
          ACKA: begin
            if (B_ACK) begin
              if (B_RW == BUS_WRITE) begin
                B_BUS_OUT <= data_sh[0];
                data_sh   <= data_sh >> 1;
                state     <= WDATA;
              end else begin
                state <= RDATA;
              end
            end
          end
          WDATA: begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              B_BUS_OUT <= 1'b0;
              state     <= ACKW;
            end else begin
              B_BUS_OUT <= data_sh[0];
              data_sh   <= data_sh >> 1;
            end
          end
          ACKW: begin
            if (B_ACK) begin
              M_DVALID <= 1'b1;
              state    <= DONE;
            end
          end
          // Read bits collect in a shadow register; RD_LAT must be at least 2
          RDATA: begin
            if (rd_active) begin
              rd_sh <= {B_BUS_IN, rd_sh[DATA_W-2:1]};
              if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                M_DOUT    <= {B_BUS_IN, rd_sh};
                M_DVALID  <= 1'b1;
                rd_active <= 1'b0;
                state     <= DONE;
              end
            end else if (!B_ACK && (tmo_cnt == CNT_W'(RD_LAT - 2))) begin
              rd_active <= 1'b1;
            end
          end
          DONE: begin
            B_VALID <= 1'b0;
            M_BUSY  <= 1'b0;
`ifdef MASTER_ARB_EN
            B_REQ   <= 1'b0;
`endif
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: a scoreboard queues expected serial bits and responses
// per request and pops them as the DUT shifts bits out and completes frames.
module tb_master_port;
  import bus_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int DW  = DEF_DATA_W;
  localparam int TMO = 15;
  localparam int RL  = 2;

  typedef struct {
    logic          err;
    logic [DW-1:0] dout;
    int            done_v;
  } resp_t;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          M_START, M_RW;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DIN;
  logic          M_BUSY;
  logic [DW-1:0] M_DOUT;
  logic          M_DVALID, M_ERR, B_VALID, B_RW, B_BUS_OUT;
  logic          B_BUS_IN, B_ACK, B_SBSY, B_READY;
`ifdef MASTER_ARB_EN
  logic          B_REQ, B_GRANT;
`endif

  int            checks = 0;
  int            errors = 0;
  logic          exp_bits[$];
  resp_t         exp_resp[$];
  logic [DW-1:0] model_dout = '0;

  always #5 CLK = ~CLK;

  master_port #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TMO), .RD_LAT(RL)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .M_START   (M_START),
    .M_RW      (M_RW),
    .M_ADDR    (M_ADDR),
    .M_DIN     (M_DIN),
    .M_BUSY    (M_BUSY),
    .M_DOUT    (M_DOUT),
    .M_DVALID  (M_DVALID),
    .M_ERR     (M_ERR),
    .B_VALID   (B_VALID),
    .B_RW      (B_RW),
    .B_BUS_OUT (B_BUS_OUT),
    .B_BUS_IN  (B_BUS_IN),
    .B_ACK     (B_ACK),
    .B_SBSY    (B_SBSY),
`ifdef MASTER_ARB_EN
    .B_REQ     (B_REQ),
    .B_GRANT   (B_GRANT),
`endif
    .B_READY   (B_READY)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One request: ack_a<0 means the slave never acks the address, drop_v>=0 removes the
  // grant in that frame cycle, rst_v>=0 pulls reset in that frame cycle.
  task automatic apply_stimulus(input string name, input logic rw, input logic [AW-1:0] addr,
                                input logic [DW-1:0] din, input logic [DW-1:0] rdata,
                                input int sbsy, input int ack_a, input int ack_len, input int ack_w,
                                input int gd, input int drop_v, input int rst_v);
    int            a_end, last_ack, done_v, vstart, v, exp_vstart;
    bit            done_seen;
    resp_t         r, got;
    logic [DW-1:0] old_dout;
    old_dout = model_dout;
    a_end    = AW + ack_a;
    last_ack = a_end + ack_len - 1;
    r.err    = 1'b0;
    r.dout   = model_dout;
    if (drop_v >= 0) begin
      r.err  = 1'b1;
      done_v = drop_v + 1;
    end else if (ack_a < 0) begin
      r.err  = 1'b1;
      done_v = AW + TMO;
    end else if (rw == BUS_WRITE) begin
      done_v = a_end + DW + 2 + ack_w;
    end else begin
      done_v = last_ack + DW + 2;
      r.dout = rdata;
    end
    r.done_v = done_v;
    for (int i = 0; i < AW; i++)
      if (drop_v < 0 || i <= drop_v) exp_bits.push_back(addr[i]);
    if (rw == BUS_WRITE && ack_a >= 0 && drop_v < 0)
      for (int i = 0; i < DW; i++) exp_bits.push_back(din[i]);
    exp_resp.push_back(r);
    exp_vstart = 1 + ((sbsy > gd) ? sbsy : gd);

    M_START = 1'b1;
    M_RW    = rw;
    M_ADDR  = addr;
    M_DIN   = din;
    B_SBSY  = (sbsy > 0);
`ifdef MASTER_ARB_EN
    B_GRANT = (gd == 0);
`endif
    tick();
    M_START = 1'b0;
    check_output({name, "_busy"}, 32'(M_BUSY), 1);
`ifdef MASTER_ARB_EN
    check_output({name, "_req"}, 32'(B_REQ), 1);
`endif
    vstart    = -1;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      B_SBSY  = (cyc < sbsy);
      M_START = 1'b0;
      if (sbsy > 0 && cyc == 2) begin
        M_START = 1'b1;
        M_ADDR  = ~addr;
        M_RW    = ~rw;
        M_DIN   = ~din;
      end
      if (vstart < 0 && B_VALID) begin
        vstart = cyc;
        check_output({name, "_vstart"}, 32'(cyc), 32'(exp_vstart));
        check_output({name, "_b_rw"}, 32'(B_RW), 32'(rw));
      end
      v = (vstart < 0) ? -1 : cyc - vstart;
      if (rst_v >= 0 && v == rst_v) begin
        #1 RSTN = 1'b0;
        #1;
        check_output({name, "_rst_valid"}, 32'(B_VALID), 0);
        check_output({name, "_rst_busy"}, 32'(M_BUSY), 0);
        check_output({name, "_rst_bus_out"}, 32'(B_BUS_OUT), 0);
        check_output({name, "_rst_dout"}, 32'(M_DOUT), 0);
        check_output({name, "_rst_err"}, 32'(M_ERR), 0);
        check_output({name, "_rst_rw"}, 32'(B_RW), 0);
        exp_bits.delete();
        exp_resp.delete();
        model_dout = '0;
        B_ACK      = 1'b0;
        B_SBSY     = 1'b0;
        tick();
        RSTN = 1'b1;
        return;
      end
      if (vstart >= 0 && ((v < AW && (drop_v < 0 || v <= drop_v)) ||
          (rw == BUS_WRITE && ack_a >= 0 && drop_v < 0 && v > a_end && v <= a_end + DW))) begin
        if (exp_bits.size() == 0) check_output({name, "_bitq_empty"}, 32'(exp_bits.size()), 1);
        else check_output($sformatf("%s_bit%0d", name, v), 32'(B_BUS_OUT), 32'(exp_bits.pop_front()));
      end
      B_ACK = 1'b0;
      if (vstart >= 0 && ack_a >= 0 && v >= a_end && v <= last_ack) B_ACK = 1'b1;
      if (vstart >= 0 && rw == BUS_WRITE && ack_a >= 0 && v == a_end + DW + 1 + ack_w) B_ACK = 1'b1;
      B_BUS_IN = 1'($urandom_range(0, 1));
      if (rw == BUS_READ && ack_a >= 0 && vstart >= 0 && v >= last_ack + 2 && v <= last_ack + DW + 1) begin
        B_BUS_IN = rdata[v - last_ack - 2];
        check_output($sformatf("%s_dout_hold%0d", name, v), 32'(M_DOUT), 32'(old_dout));
      end
`ifdef MASTER_ARB_EN
      B_GRANT = (cyc >= gd) && !(drop_v >= 0 && vstart >= 0 && v >= drop_v);
`endif
      if (M_DVALID || M_ERR) begin
        done_seen = 1'b1;
        if (exp_resp.size() == 0) begin
          check_output({name, "_respq_empty"}, 32'(exp_resp.size()), 1);
        end else begin
          got = exp_resp.pop_front();
          check_output({name, "_err"}, 32'(M_ERR), 32'(got.err));
          check_output({name, "_dvalid"}, 32'(M_DVALID), 32'(!got.err));
          check_output({name, "_dout"}, 32'(M_DOUT), 32'(got.dout));
          check_output({name, "_done_cycle"}, 32'(v), 32'(got.done_v));
          if (got.err) begin
            check_output({name, "_err_valid"}, 32'(B_VALID), 0);
`ifdef MASTER_ARB_EN
            check_output({name, "_err_req"}, 32'(B_REQ), 0);
`endif
          end
        end
      end
      if (!done_seen) tick();
    end
    check_output({name, "_frame_done"}, 32'(done_seen), 1);
    check_output({name, "_bits_left"}, 32'(exp_bits.size()), 0);
    model_dout = r.dout;
    B_ACK  = 1'b0;
    B_SBSY = 1'b0;
    tick();
    check_output({name, "_post_busy"}, 32'(M_BUSY), 0);
    check_output({name, "_post_valid"}, 32'(B_VALID), 0);
    check_output({name, "_post_pulse"}, 32'({M_DVALID, M_ERR}), 0);
`ifdef MASTER_ARB_EN
    check_output({name, "_post_req"}, 32'(B_REQ), 0);
    B_GRANT = 1'b1;
`endif
  endtask

  initial begin
    RSTN     = 1'b0;
    M_START  = 1'b0;
    M_RW     = 1'b0;
    M_ADDR   = '0;
    M_DIN    = '0;
    B_BUS_IN = 1'b0;
    B_ACK    = 1'b0;
    B_SBSY   = 1'b0;
    B_READY  = 1'b1;
`ifdef MASTER_ARB_EN
    B_GRANT  = 1'b0;
`endif
    repeat (2) tick();
    check_output("reset_busy", 32'(M_BUSY), 0);
    check_output("reset_valid", 32'(B_VALID), 0);
    check_output("reset_dout", 32'(M_DOUT), 0);
    check_output("reset_pulses", 32'({M_DVALID, M_ERR}), 0);
    check_output("reset_bus", 32'({B_RW, B_BUS_OUT}), 0);
    RSTN = 1'b1;
    tick();

    $display("[TB] write 0x0123 <= 0xA5");
    apply_stimulus("wr", BUS_WRITE, 15'h0123, 8'hA5, 8'h00, 0, 1, 1, 1, 0, -1, -1);
    $display("[TB] read 0x7FFF returning 0x3C");
    apply_stimulus("rd", BUS_READ, 15'h7FFF, 8'h00, 8'h3C, 0, 0, 1, 0, 0, -1, -1);
    $display("[TB] read with late, two-cycle ack");
    apply_stimulus("rd2", BUS_READ, 15'h2A55, 8'h00, 8'hC3, 0, 3, 2, 0, 0, -1, -1);
    $display("[TB] address ack timeout");
    apply_stimulus("tmo", BUS_WRITE, 15'h1111, 8'h77, 8'h00, 0, -1, 1, 0, 0, -1, -1);
    $display("[TB] slave busy for 5 cycles, repeated start ignored");
    apply_stimulus("sbsy", BUS_WRITE, 15'h4E21, 8'h96, 8'h00, 5, 0, 1, 2, 0, -1, -1);
    $display("[TB] reset during write data");
    apply_stimulus("rstmid", BUS_WRITE, 15'h3333, 8'hF0, 8'h00, 0, 0, 1, 0, 0, -1, 18);
    apply_stimulus("wr5a", BUS_WRITE, 15'h0ABC, 8'h5A, 8'h00, 0, 0, 1, 0, 0, -1, -1);
    apply_stimulus("rd81", BUS_READ, 15'h0ABC, 8'h00, 8'h81, 0, 0, 1, 0, 0, -1, -1);
`ifdef MASTER_ARB_EN
    $display("[TB] grant delayed 3 cycles");
    apply_stimulus("gnt", BUS_WRITE, 15'h0F0F, 8'h3C, 8'h00, 0, 0, 1, 0, 3, -1, -1);
    $display("[TB] grant dropped during address phase");
    apply_stimulus("drop", BUS_READ, 15'h7001, 8'h00, 8'h11, 0, 0, 1, 0, 0, 6, -1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
